// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - multi-cycle RV32M multiply/divide execute unit
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] reg1_rdata_i,
    input  logic [31:0] reg2_rdata_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        abort_i,
    output logic        hold_req_o,
    output logic        busy_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        is_m, start, div_signed, a_neg, b_neg;
    logic [2:0]  f3_in;
    logic [63:0] mul_a, mul_b, product;
    logic [32:0] rem_shift, rem_diff;
    logic        unused_inst;

    assign f3_in       = inst_i[14:12];
    assign is_m        = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001);
    assign start       = (state_q == S_IDLE) && is_m && !abort_i;
    assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};

    assign div_signed = ~f3_in[0];
    assign a_neg      = div_signed & reg1_rdata_i[31];
    assign b_neg      = div_signed & reg2_rdata_i[31];

    // Low 64 bits of the sign/zero-extended product are exact for every variant.
    assign mul_a   = {{32{(funct3_q != 3'd3) & op1_q[31]}}, op1_q};
    assign mul_b   = {{32{~funct3_q[1] & op2_q[31]}}, op2_q};
    assign product = mul_a * mul_b;

    // op1 holds the dividend magnitude and fills with quotient bits from the LSB.
    assign rem_shift = {rem_q, op1_q[31]};
    assign rem_diff  = rem_shift - {1'b0, op2_q};

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        rem_d    = rem_q;
        cnt_d    = 5'd0;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        we_d     = 1'b0;
        waddr_d  = 5'd0;
        wdata_d  = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    funct3_d = f3_in;
                    rd_d     = reg_waddr_i;
                    rem_d    = 32'd0;
                    q_neg_d  = a_neg ^ b_neg;
                    r_neg_d  = a_neg;
                    if (!f3_in[2]) begin
                        op1_d   = reg1_rdata_i;
                        op2_d   = reg2_rdata_i;
                        state_d = S_MUL;
                    end else if (reg2_rdata_i == 32'd0) begin
                        op1_d   = reg1_rdata_i;
                        op2_d   = reg2_rdata_i;
                        state_d = S_DONE;
                        we_d    = 1'b1;
                        waddr_d = reg_waddr_i;
                        wdata_d = f3_in[1] ? reg1_rdata_i : 32'hFFFF_FFFF;
                    end else begin
                        op1_d   = a_neg ? (32'd0 - reg1_rdata_i) : reg1_rdata_i;
                        op2_d   = b_neg ? (32'd0 - reg2_rdata_i) : reg2_rdata_i;
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                state_d = S_DONE;
                we_d    = 1'b1;
                waddr_d = rd_q;
                wdata_d = (funct3_q == 3'd0) ? product[31:0] : product[63:32];
            end
            S_DIV: begin
                op1_d = {op1_q[30:0], ~rem_diff[32]};
                rem_d = rem_diff[32] ? rem_shift[31:0] : rem_diff[31:0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                we_d    = 1'b1;
                waddr_d = rd_q;
                if (funct3_q[1]) begin
                    wdata_d = r_neg_q ? (32'd0 - rem_q) : rem_q;
                end else begin
                    wdata_d = q_neg_q ? (32'd0 - op1_q) : op1_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_i) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
            we_d    = 1'b0;
            waddr_d = 5'd0;
            wdata_d = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            funct3_q <= 3'd0;
            rd_q     <= 5'd0;
            op1_q    <= 32'd0;
            op2_q    <= 32'd0;
            rem_q    <= 32'd0;
            cnt_q    <= 5'd0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= 5'd0;
            wdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // DONE drops the hold so ID/EX can load the next instruction on that edge.
    assign hold_req_o  = start || (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign busy_o      = (state_q != S_IDLE);
    assign reg_we_o    = we_q;
    assign reg_waddr_o = waddr_q;
    assign reg_wdata_o = wdata_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i;
    logic [31:0] reg1_rdata_i;
    logic [31:0] reg2_rdata_i;
    logic [4:0]  reg_waddr_i;
    logic        abort_i;
    logic        hold_req_o;
    logic        busy_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;

    ex_muldiv dut (
        .clk          (clk),
        .rst          (rst),
        .inst_i       (inst_i),
        .reg1_rdata_i (reg1_rdata_i),
        .reg2_rdata_i (reg2_rdata_i),
        .reg_waddr_i  (reg_waddr_i),
        .abort_i      (abort_i),
        .hold_req_o   (hold_req_o),
        .busy_o       (busy_o),
        .reg_we_o     (reg_we_o),
        .reg_waddr_o  (reg_waddr_o),
        .reg_wdata_o  (reg_wdata_o)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int          tests = 0;
    int          fails = 0;
    int          wr_count = 0;
    logic        chk_en = 1'b0;
    logic        exp_hold = 1'b0, exp_busy = 1'b0, exp_we = 1'b0;
    logic [4:0]  exp_waddr = 5'd0;
    logic [31:0] exp_wdata = 32'd0, exp_lit = 32'd0;
    logic        cnt_chk = 1'b0;
    int          exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("hold_req_o", 32'(hold_req_o), 32'(exp_hold));
            check("busy_o", 32'(busy_o), 32'(exp_busy));
            check("reg_we_o", 32'(reg_we_o), 32'(exp_we));
            check("reg_waddr_o", 32'(reg_waddr_o), 32'(exp_waddr));
            check("reg_wdata_o", reg_wdata_o, exp_wdata);
            if (exp_we) check("wdata_literal", reg_wdata_o, exp_lit);
            if (cnt_chk) check("write_count", 32'(wr_count), 32'(exp_cnt));
        end
        if (reg_we_o) wr_count++;
    end

    // Architectural RV32M result from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic logic [31:0] m_inst(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    task automatic cyc(input logic h, input logic b, input logic w,
                       input logic [4:0] a, input logic [31:0] d, input logic [31:0] l);
        exp_hold  = h;
        exp_busy  = b;
        exp_we    = w;
        exp_waddr = a;
        exp_wdata = d;
        exp_lit   = l;
        @(posedge clk);
        #1;
    endtask

    // Holds the instruction like ID/EX would, through its DONE cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] lit);
        int          lat;
        logic [31:0] r;
        r   = model(f3, a, b);
        lat = f3[2] ? ((b == 32'd0) ? 1 : 34) : 2;
        inst_i       = m_inst(f3, rd);
        reg1_rdata_i = a;
        reg2_rdata_i = b;
        reg_waddr_i  = rd;
        for (int c = 0; c <= lat; c++)
            cyc(c < lat, c > 0, c == lat, (c == lat) ? rd : 5'd0, (c == lat) ? r : 32'd0, lit);
        inst_i = NOP;
    endtask

    int base;

    initial begin
        rst = 1'b1; abort_i = 1'b0; inst_i = 32'd0;
        reg1_rdata_i = 32'd0; reg2_rdata_i = 32'd0; reg_waddr_i = 5'd0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        cyc(0, 0, 0, 5'd0, 32'd0, 32'd0);
        rst = 1'b0;
        cyc(0, 0, 0, 5'd0, 32'd0, 32'd0);

        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0003, 5'd5, 32'hFFFF_FFFD);
        run_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0003, 5'd6, 32'h0000_0002);
        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0003, 5'd7, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0003, 5'd8, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF);
        run_op(3'd5, 32'h0000_0005, 32'h0000_0000, 5'd11, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h0000_0005, 32'h0000_0000, 5'd12, 32'h0000_0005);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000);
        run_op(3'd7, 32'd100, 32'd7, 5'd0, 32'h0000_0002);
        run_op(3'd4, 32'd100, 32'hFFFF_FFF9, 5'd15, 32'hFFFF_FFF2);
        run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd16, 32'hFFFF_FFFE);

        // Non-M R-type and abort in IDLE must not start anything.
        inst_i = {7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
        cyc(0, 0, 0, 5'd0, 32'd0, 32'd0);
        inst_i = m_inst(3'd0, 5'd3); abort_i = 1'b1;
        cyc(0, 0, 0, 5'd0, 32'd0, 32'd0);
        inst_i = NOP; abort_i = 1'b0;
        cyc(0, 0, 0, 5'd0, 32'd0, 32'd0);

        // Abort in the middle of a divide.
        base = wr_count;
        inst_i = m_inst(3'd4, 5'd4); reg1_rdata_i = 32'd100; reg2_rdata_i = 32'd7; reg_waddr_i = 5'd4;
        for (int c = 0; c <= 10; c++) begin
            abort_i = (c == 10);
            cyc(1, c > 0, 0, 5'd0, 32'd0, 32'd0);
        end
        inst_i = NOP; abort_i = 1'b0;
        for (int c = 0; c < 3; c++) cyc(0, 0, 0, 5'd0, 32'd0, 32'd0);
        exp_cnt = base; cnt_chk = 1'b1;
        cyc(0, 0, 0, 5'd0, 32'd0, 32'd0);
        cnt_chk = 1'b0;

        // Back-to-back: write pulses at cycles 2 and 37.
        base = wr_count;
        run_op(3'd0, 32'd3, 32'd5, 5'd17, 32'd15);
        run_op(3'd5, 32'd100, 32'd7, 5'd18, 32'd14);
        exp_cnt = base + 2; cnt_chk = 1'b1;
        cyc(0, 0, 0, 5'd0, 32'd0, 32'd0);
        cnt_chk = 1'b0;

        // Asynchronous reset mid-divide, checked before any further clock edge.
        inst_i = m_inst(3'd4, 5'd19); reg1_rdata_i = 32'd100; reg2_rdata_i = 32'd7; reg_waddr_i = 5'd19;
        for (int c = 0; c < 5; c++) cyc(1, c > 0, 0, 5'd0, 32'd0, 32'd0);
        rst = 1'b1; inst_i = NOP;
        cyc(0, 0, 0, 5'd0, 32'd0, 32'd0);
        rst = 1'b0;
        cyc(0, 0, 0, 5'd0, 32'd0, 32'd0);

        // Asynchronous reset while the write pulse is on the outputs.
        inst_i = m_inst(3'd0, 5'd20); reg1_rdata_i = 32'd7; reg2_rdata_i = 32'd6; reg_waddr_i = 5'd20;
        cyc(1, 0, 0, 5'd0, 32'd0, 32'd0);
        cyc(1, 1, 0, 5'd0, 32'd0, 32'd0);
        rst = 1'b1; inst_i = NOP;
        cyc(0, 0, 0, 5'd0, 32'd0, 32'd0);
        rst = 1'b0;
        cyc(0, 0, 0, 5'd0, 32'd0, 32'd0);
        run_op(3'd0, 32'd7, 32'd6, 5'd21, 32'd42);
        cyc(0, 0, 0, 5'd0, 32'd0, 32'd0);

        chk_en = 1'b0;
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle RV32M execution unit in the execute stage, directly downstream of the ID/EX pipeline register. It decodes the instruction word and register operands the ID/EX register presents and runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. While an operation is in flight it raises a hold request so that ID/EX and everything upstream freeze. It returns the result as a one-cycle register write.

## Interface
- No parameters.
- `clk` in 1: core clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inst_i` in 32: instruction from ID/EX.
- `reg1_rdata_i` in 32: rs1 value from ID/EX.
- `reg2_rdata_i` in 32: rs2 value from ID/EX.
- `reg_waddr_i` in 5: rd from ID/EX.
- `abort_i` in 1: interrupt/exception abort; kills any in-flight operation.
- `hold_req_o` out 1: stall request to ctrl, mapped to the Hold_Id level.
- `busy_o` out 1: state is not IDLE.
- `reg_we_o` out 1: write enable for rd.
- `reg_waddr_o` out 5: write address.
- `reg_wdata_o` out 32: write data.

## Operation
- M-instruction match: opcode 7'b0110011 and funct7 7'b0000001. funct3 selects the operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, with a match and no `abort_i`:
  - Capture operands, funct3 and rd.
  - Multiply → MUL.
  - Divide with rs2 == 0 → DONE directly.
  - Other divide → DIV, after loading operand magnitudes (signed ops only) and the quotient/remainder sign flags.
- MUL: register the 64-bit product of 33-bit sign/zero-extended operands (rs1 signed for MUL/MULH/MULHSU; rs2 signed for MUL/MULH). → DONE.
- MUL result selection: MUL takes product[31:0]; the others take [63:32].
- DIV: restoring radix-2, one quotient bit per cycle. A 5-bit counter runs 0..31, and the state leaves DIV when the counter reaches 31. → FIX.
- FIX sign correction:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Unsigned ops pass through unchanged. → DONE.
- Overflow: −2^31 / −1 yields quotient 0x80000000 and remainder 0. This falls out of the magnitude datapath; no special case.
- Divide by zero: quotient 0xFFFFFFFF, remainder = rs1, both unmodified.
- DONE: `reg_we_o`=1, `reg_waddr_o`=captured rd, `reg_wdata_o`=result for exactly one cycle. → IDLE. A match seen in DONE is not started, because it is still the completed instruction.
- rd = x0 is still written (`reg_we_o`=1, addr 0); the register file discards it.
- `abort_i` in any state: next state IDLE, no write issued, counter cleared. In IDLE it blocks the start.

## Timing
- Reset values: state IDLE; `hold_req_o`=0, `busy_o`=0, `reg_we_o`=0, `reg_waddr_o`=0, `reg_wdata_o`=0, counter 0.
- `hold_req_o` (combinational) = (IDLE & match & ~abort_i) | MUL | DIV | FIX. It is 0 in DONE, so ID/EX loads the next instruction on the DONE edge.
- Outputs `reg_*` are registered: nonzero only in DONE, 0 otherwise.
- Latency, counted from the cycle (0) in which the instruction first appears:
  - Multiply: DONE at cycle 2; hold in cycles 0–1.
  - Divide: DIV in cycles 1–32, FIX in 33, DONE in 34; hold in cycles 0–33.
  - Divide by zero: DONE at cycle 1; hold in cycle 0 only.
- Back-to-back M-instructions: the second appears in the cycle after DONE (state IDLE) and starts normally.
- Asynchronous reset mid-operation: all state is cleared immediately and no write is produced.

## Test plan
- MUL rs1=0xFFFFFFFF, rs2=0x00000003 → DONE at cycle 2 writes 0xFFFFFFFD; MULHU on the same operands writes 0x00000002; MULH writes 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (−7), rs2=2 → hold high for cycles 0–33, DONE at cycle 34 writes 0xFFFFFFFD; REM on the same operands writes 0xFFFFFFFF.
- DIVU rs1=5, rs2=0 → DONE at cycle 1 writes 0xFFFFFFFF; REM rs1=5, rs2=0 writes 0x00000005.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF → writes 0x80000000; REM on the same operands writes 0.
- DIV started, `abort_i` pulsed at cycle 10 → IDLE at cycle 11, `hold_req_o`=0, no `reg_we_o` pulse.
- Back-to-back MUL then DIVU 100/7 → two single-cycle write pulses: first at cycle 2, second at cycle 37 with value 14; `rst` asserted mid-DIV clears all outputs to 0 asynchronously.
